// File: rtl/cnn_stream_pkg.sv
// rtl/cnn_stream_pkg.sv - shared FSM type, config addresses and width helper for cnn_stream_engine
package cnn_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [3:0] CFG_W_LAST = 4'd8;
    localparam logic [3:0] CFG_SHIFT  = 4'd9;
    localparam logic [3:0] CFG_BIAS   = 4'd10;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnn_stream_if.sv
// rtl/cnn_stream_if.sv - pixel-in / pooled-out valid-ready stream pair for cnn_stream_engine
interface cnn_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DATA_WIDTH-1:0] in_data_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] out_data_o;

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o
    );

    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o
    );
endinterface

// File: rtl/cnn_line_window.sv
// rtl/cnn_line_window.sv - two line buffers, 3x3 shift window and row/col tracking
module cnn_line_window
    import cnn_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    localparam int CW        = cnt_w(IMG_W),
    localparam int RW        = cnt_w(IMG_H)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       en_i,
    input  logic                       accept_i,
    input  logic [DATA_WIDTH-1:0]      pix_i,
    output logic [8:0][DATA_WIDTH-1:0] win_o,
    output logic                       win_valid_o,
    output logic [RW-1:0]              conv_row_o,
    output logic [CW-1:0]              conv_col_o,
    output logic                       last_o
);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0] col_q, col_d, conv_col_q, conv_col_d;
    logic [RW-1:0] row_q, row_d, conv_row_q, conv_row_d;
    logic [IMG_W-1:0][DATA_WIDTH-1:0] lb0_q, lb0_d, lb1_q, lb1_d;
    logic [8:0][DATA_WIDTH-1:0] win_q, win_d;
    logic win_valid_q, win_valid_d;

    // win index is row-major with 0 = oldest row, oldest column
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        lb0_d       = lb0_q;
        lb1_d       = lb1_q;
        win_d       = win_q;
        win_valid_d = win_valid_q;
        conv_row_d  = conv_row_q;
        conv_col_d  = conv_col_q;
        if (clr_i) begin
            col_d       = '0;
            row_d       = '0;
            win_valid_d = 1'b0;
        end else if (accept_i) begin
            lb1_d[col_q] = lb0_q[col_q];
            lb0_d[col_q] = pix_i;
            for (int r = 0; r < 3; r++) begin
                win_d[r*3+0] = win_q[r*3+1];
                win_d[r*3+1] = win_q[r*3+2];
            end
            win_d[2]    = lb1_q[col_q];
            win_d[5]    = lb0_q[col_q];
            win_d[8]    = pix_i;
            win_valid_d = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
            conv_row_d  = row_q - ROW_TWO;
            conv_col_d  = col_q - COL_TWO;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end else if (en_i) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q       <= '0;
            row_q       <= '0;
            lb0_q       <= '0;
            lb1_q       <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            conv_row_q  <= '0;
            conv_col_q  <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            lb0_q       <= lb0_d;
            lb1_q       <= lb1_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
            conv_row_q  <= conv_row_d;
            conv_col_q  <= conv_col_d;
        end
    end

    assign win_o       = win_q;
    assign win_valid_o = win_valid_q;
    assign conv_row_o  = conv_row_q;
    assign conv_col_o  = conv_col_q;
    assign last_o      = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/cnn_stream_engine.sv
// rtl/cnn_stream_engine.sv - 3x3 conv, ReLU, requant and 2x2 max-pool stream engine
// CNN_BIAS_EN adds a signed bias register at config address 10.
module cnn_stream_engine
    import cnn_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_we_i,
    input  logic [3:0]           cfg_addr_i,
    input  logic [ACC_WIDTH-1:0] cfg_wdata_i,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    cnn_stream_if.slave          strm
);
    localparam int CW  = cnt_w(IMG_W);
    localparam int RW  = cnt_w(IMG_H);
    localparam int PW  = (IMG_W - 2) / 2;
    localparam int PH  = (IMG_H - 2) / 2;
    localparam int PIW = cnt_w(PW);
    localparam logic [CW-1:0] COL_KEEP = CW'(2 * PW);
    localparam logic [RW-1:0] ROW_KEEP = RW'(2 * PH);
    localparam logic [ACC_WIDTH-1:0] PIX_MAX = ACC_WIDTH'((1 << DATA_WIDTH) - 1);

    state_t state_q, state_d;
    logic [8:0][DATA_WIDTH-1:0] w_q, w_d;
    logic [3:0] shift_q, shift_d;
`ifdef CNN_BIAS_EN
    logic [ACC_WIDTH-1:0] bias_q, bias_d;
`else
    logic unused_wdata;
    assign unused_wdata = ^cfg_wdata_i[ACC_WIDTH-1:DATA_WIDTH];
`endif

    logic en, in_ready, accept, last_pix, win_valid;
    logic [8:0][DATA_WIDTH-1:0] win;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;

    logic s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d, pair_q, pair_d, out_data_q, out_data_d;
    logic [RW-1:0] s1_row_q, s1_row_d;
    logic [CW-1:0] s1_col_q, s1_col_d;
    logic [PW-1:0][DATA_WIDTH-1:0] pool_q, pool_d;

    logic signed [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] requant, pair_max, blk_max;
    logic [PIW-1:0] pidx;

    // one global stall: nothing moves while a result waits at the output
    assign en       = !out_valid_q || strm.out_ready_i;
    assign in_ready = (state_q == RUN) && en;
    assign accept   = strm.in_valid_i && in_ready;

    cnn_line_window #(
        .DATA_WIDTH (DATA_WIDTH),
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H)
    ) u_window (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       ((state_q == IDLE) && start_i),
        .en_i        (en),
        .accept_i    (accept),
        .pix_i       (strm.in_data_i),
        .win_o       (win),
        .win_valid_o (win_valid),
        .conv_row_o  (win_row),
        .conv_col_o  (win_col),
        .last_o      (last_pix)
    );

    always_comb begin
        w_d     = w_q;
        shift_d = shift_q;
`ifdef CNN_BIAS_EN
        bias_d  = bias_q;
`endif
        if (cfg_we_i && (state_q == IDLE)) begin
            if (cfg_addr_i <= CFG_W_LAST) w_d[cfg_addr_i] = cfg_wdata_i[DATA_WIDTH-1:0];
            else if (cfg_addr_i == CFG_SHIFT) shift_d = cfg_wdata_i[3:0];
`ifdef CNN_BIAS_EN
            else if (cfg_addr_i == CFG_BIAS) bias_d = cfg_wdata_i;
`endif
        end
    end

    always_comb begin
`ifdef CNN_BIAS_EN
        acc = $signed(bias_q);
`else
        acc = '0;
`endif
        for (int k = 0; k < 9; k++) begin
            acc = acc + $signed(ACC_WIDTH'($signed(w_q[k]))) * $signed(ACC_WIDTH'({1'b0, win[k]}));
        end
        shifted = acc[ACC_WIDTH-1] ? '0 : ($unsigned(acc) >> shift_q);
        requant = (shifted > PIX_MAX) ? '1 : shifted[DATA_WIDTH-1:0];
    end

    // even conv rows park pair maxima in pool_q; odd rows finish the 2x2 block
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_row_d    = s1_row_q;
        s1_col_d    = s1_col_q;
        pair_d      = pair_q;
        pool_d      = pool_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        pidx        = PIW'(s1_col_q >> 1);
        pair_max    = (s1_data_q > pair_q) ? s1_data_q : pair_q;
        blk_max     = (pool_q[pidx] > pair_max) ? pool_q[pidx] : pair_max;
        if (en) begin
            s1_valid_d  = win_valid;
            s1_data_d   = requant;
            s1_row_d    = win_row;
            s1_col_d    = win_col;
            out_valid_d = 1'b0;
            if (s1_valid_q && (s1_row_q < ROW_KEEP) && (s1_col_q < COL_KEEP)) begin
                if (!s1_col_q[0]) begin
                    pair_d = s1_data_q;
                end else if (!s1_row_q[0]) begin
                    pool_d[pidx] = pair_max;
                end else begin
                    out_valid_d = 1'b1;
                    out_data_d  = blk_max;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (accept && last_pix) state_d = DRAIN;
            DRAIN:   if (!win_valid && !s1_valid_q && en) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            w_q         <= '0;
            shift_q     <= '0;
`ifdef CNN_BIAS_EN
            bias_q      <= '0;
`endif
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_row_q    <= '0;
            s1_col_q    <= '0;
            pair_q      <= '0;
            pool_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            shift_q     <= shift_d;
`ifdef CNN_BIAS_EN
            bias_q      <= bias_d;
`endif
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_row_q    <= s1_row_d;
            s1_col_q    <= s1_col_d;
            pair_q      <= pair_d;
            pool_q      <= pool_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign strm.in_ready_o  = in_ready;
    assign strm.out_valid_o = out_valid_q;
    assign strm.out_data_o  = out_data_q;
    assign busy_o           = (state_q != IDLE);
    assign done_o           = (state_q == DONE);

endmodule
